// File: rtl/cmd_issuer_if.sv
`default_nettype none
// ============================================================================
// Module  : cmd_issuer_if
// Brief   : Host command, SYSTEM issue and read-response bundle for cmd_issuer.
// Revision: 1.0 - initial release
// ============================================================================
interface cmd_issuer_if #(
  parameter int DEPTH = 4
);
  localparam int c_CW = $clog2(DEPTH) + 1;

  logic            CMD_VALID;
  logic            CMD_READY;
  logic [31:0]     CMD_OPCODE;
  logic [31:0]     CMD_DATA;
  logic [31:0]     OPCODE;
  logic [31:0]     DATA;
  logic            DONE;
  logic            WAIT;
  logic [31:0]     RESPONSE;
  logic [4:0]      RESPONSE_ADDR;
  logic            RSP_VALID;
  logic            RSP_READY;
  logic [31:0]     RSP_DATA;
  logic [4:0]      RSP_ADDR;
  logic            BUSY;
  logic            ERR;
  logic [c_CW-1:0] COUNT;

  modport master (
    input  CMD_VALID, CMD_OPCODE, CMD_DATA, DONE, WAIT, RESPONSE, RESPONSE_ADDR, RSP_READY,
    output CMD_READY, OPCODE, DATA, RSP_VALID, RSP_DATA, RSP_ADDR, BUSY, ERR, COUNT
  );

  modport slave (
    output CMD_VALID, CMD_OPCODE, CMD_DATA, DONE, WAIT, RESPONSE, RESPONSE_ADDR, RSP_READY,
    input  CMD_READY, OPCODE, DATA, RSP_VALID, RSP_DATA, RSP_ADDR, BUSY, ERR, COUNT
  );
endinterface
`default_nettype wire

// File: rtl/cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module  : cmd_issuer
// Brief   : FIFO-buffered load/store issue stage driving SYSTEM OPCODE/DATA.
//           Optional DONE timeout enabled by macro CMD_ISSUER_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module cmd_issuer #(
  parameter int DEPTH   = 4
`ifdef CMD_ISSUER_TIMEOUT_EN
  , parameter int TIMEOUT = 16
`endif
) (
  input  wire logic    HCLK,
  input  wire logic    HRESET,
  cmd_issuer_if.master bus
);
  localparam int          c_AW      = $clog2(DEPTH);
  localparam int          c_CW      = c_AW + 1;
  localparam logic [31:0] c_IDLE_OP = 32'hFC000001;
  localparam logic [5:0]  c_CLS_WR  = 6'b101011;
  localparam logic [5:0]  c_CLS_RD  = 6'b100011;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [31:0]     r_mem_op   [DEPTH];
  logic [31:0]     r_mem_data [DEPTH];
  logic [c_AW-1:0] r_wptr;
  logic [c_AW-1:0] r_rptr;
  logic [c_CW-1:0] r_count;
  logic [31:0]     r_iss_op;
  logic [31:0]     r_iss_data;
  logic [31:0]     r_rsp_data;
  logic [4:0]      r_rsp_addr;
  logic            r_err;

  logic            w_ready;
  logic            w_push;
  logic            w_pop;
  logic            w_load;
  logic            w_drop;
  logic            w_head_legal;
  logic            w_iss_read;
  logic            w_done_rd;
  logic            w_tmo_hit;
  logic [31:0]     w_head_op;
  logic [31:0]     w_opcode;

  assign w_ready      = !HRESET && (r_count < c_CW'(DEPTH));
  assign w_push       = bus.CMD_VALID && w_ready;
  assign w_head_op    = r_mem_op[r_rptr];
  assign w_head_legal = (w_head_op[31:26] == c_CLS_WR) || (w_head_op[31:26] == c_CLS_RD);
  assign w_pop        = (r_state == S_IDLE) && (r_count != '0) && !bus.WAIT;
  assign w_load       = w_pop && w_head_legal;
  assign w_drop       = w_pop && !w_head_legal;
  assign w_iss_read   = (r_iss_op[31:26] == c_CLS_RD);
  assign w_done_rd    = (r_state == S_ISSUE) && bus.DONE && w_iss_read;

`ifdef CMD_ISSUER_TIMEOUT_EN
  localparam int c_TW = $clog2(TIMEOUT) + 1;

  logic [c_TW-1:0] r_tmo;
  logic            w_tmo_inc;

  // WAIT cycles are not charged against the command's DONE budget
  assign w_tmo_inc = (r_state == S_ISSUE) && !bus.DONE && !bus.WAIT;
  assign w_tmo_hit = w_tmo_inc && (r_tmo == c_TW'(TIMEOUT - 1));

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_tmo <= '0;
    end else if (w_load) begin
      r_tmo <= '0;
    end else if (w_tmo_inc) begin
      r_tmo <= r_tmo + c_TW'(1);
    end
  end
`else
  assign w_tmo_hit = 1'b0;
`endif

  always_ff @(posedge HCLK) begin
    if (w_push) begin
      r_mem_op[r_wptr]   <= bus.CMD_OPCODE;
      r_mem_data[r_wptr] <= bus.CMD_DATA;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state    <= S_IDLE;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_iss_op   <= c_IDLE_OP;
      r_iss_data <= '0;
      r_rsp_data <= '0;
      r_rsp_addr <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_push) begin
        r_wptr <= r_wptr + c_AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_load) begin
        r_iss_op   <= w_head_op;
        r_iss_data <= r_mem_data[r_rptr];
      end
      if (w_done_rd) begin
        r_rsp_data <= bus.RESPONSE;
        r_rsp_addr <= bus.RESPONSE_ADDR;
      end
      r_err <= w_drop || w_tmo_hit;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_opcode = c_IDLE_OP;
    case (r_state)
      S_IDLE: begin
        if (w_load) begin
          w_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_opcode = r_iss_op;
        // DONE wins over a timeout landing on the same edge
        if (bus.DONE) begin
          w_next = w_iss_read ? S_RESP : S_IDLE;
        end else if (w_tmo_hit) begin
          w_next = S_IDLE;
        end
      end
      S_RESP: begin
        if (bus.RSP_READY) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign bus.CMD_READY = w_ready;
  assign bus.OPCODE    = w_opcode;
  assign bus.DATA      = r_iss_data;
  assign bus.RSP_VALID = (r_state == S_RESP);
  assign bus.RSP_DATA  = r_rsp_data;
  assign bus.RSP_ADDR  = r_rsp_addr;
  assign bus.BUSY      = (r_state != S_IDLE) || (r_count != '0);
  assign bus.ERR       = r_err;
  assign bus.COUNT     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module  : tb_cmd_issuer
// Brief   : Scoreboard bench for cmd_issuer (honours CMD_ISSUER_TIMEOUT_EN).
// Revision: 1.0 - initial release
// ============================================================================
module tb_cmd_issuer;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] c_IDLE = 32'hFC000001;

  logic        HCLK      = 1'b0;
  logic        HRESET    = 1'b1;
  logic        auto_mode = 1'b0;
  logic        prev_idle = 1'b1;
  int          n_total   = 0;
  int          n_bad     = 0;
  int          n_err     = 0;
  logic [63:0] q_iss [$];
  logic [36:0] q_rsp [$];

  cmd_issuer_if #(.DEPTH(DEPTH)) bus ();

  cmd_issuer #(
    .DEPTH(DEPTH)
`ifdef CMD_ISSUER_TIMEOUT_EN
    , .TIMEOUT(16)
`endif
  ) u_dut (
    .HCLK  (HCLK),
    .HRESET(HRESET),
    .bus   (bus)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Holds CMD_VALID until accepted; queues the command if it should reach SYSTEM
  task automatic push(input logic [31:0] op, input logic [31:0] d, input bit expect_issue);
    int n = 0;
    bus.CMD_VALID  = 1'b1;
    bus.CMD_OPCODE = op;
    bus.CMD_DATA   = d;
    while (!bus.CMD_READY && n < 200) begin
      @(posedge HCLK); #1;
      n++;
    end
    if (n >= 200) chk("push_timeout", 32'(bus.CMD_READY), 32'd1);
    @(posedge HCLK); #1;
    bus.CMD_VALID = 1'b0;
    if (expect_issue) q_iss.push_back({op, d});
  endtask

  task automatic wait_issue();
    bit seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge HCLK);
      if (bus.OPCODE != c_IDLE) begin
        seen = 1'b1;
        break;
      end
    end
    chk("issue_seen", 32'(seen), 32'd1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300; i++) begin
      @(negedge HCLK);
      if (!bus.BUSY) break;
    end
    chk("drained", 32'(bus.BUSY), 32'd0);
  endtask

  // Monitor: scores every new command on OPCODE and every response handshake
  initial begin
    logic [63:0] e;
    logic [36:0] r;
    forever begin
      @(negedge HCLK);
      if (!HRESET) begin
        if (bus.ERR) n_err++;
        if (bus.OPCODE != c_IDLE && prev_idle) begin
          if (q_iss.size() == 0) begin
            chk("issue_unexpected", bus.OPCODE, c_IDLE);
          end else begin
            e = q_iss.pop_front();
            chk("issue_op", bus.OPCODE, e[63:32]);
            chk("issue_data", bus.DATA, e[31:0]);
          end
        end
        prev_idle = (bus.OPCODE == c_IDLE);
        if (bus.RSP_VALID && bus.RSP_READY) begin
          if (q_rsp.size() == 0) begin
            chk("rsp_unexpected", 32'(bus.RSP_VALID), 32'd0);
          end else begin
            r = q_rsp.pop_front();
            chk("rsp_data", bus.RSP_DATA, r[31:0]);
            chk("rsp_addr", 32'(bus.RSP_ADDR), 32'(r[36:32]));
          end
        end
      end
    end
  end

  // Auto responder: completes each command one cycle after it appears
  initial begin
    forever begin
      @(negedge HCLK);
      if (auto_mode) begin
        if (bus.OPCODE != c_IDLE && !bus.DONE) begin
          bus.DONE          = 1'b1;
          bus.RESPONSE      = $urandom;
          bus.RESPONSE_ADDR = 5'($urandom_range(0, 31));
          if (bus.OPCODE[31:26] == 6'b100011) q_rsp.push_back({bus.RESPONSE_ADDR, bus.RESPONSE});
        end else begin
          bus.DONE = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    int e0;
    int nw;
    bit hit;
    bus.CMD_VALID     = 1'b0;
    bus.CMD_OPCODE    = '0;
    bus.CMD_DATA      = '0;
    bus.DONE          = 1'b0;
    bus.WAIT          = 1'b0;
    bus.RESPONSE      = '0;
    bus.RESPONSE_ADDR = '0;
    bus.RSP_READY     = 1'b0;
    repeat (3) @(posedge HCLK);
    #1 HRESET = 1'b0;

    @(negedge HCLK);
    chk("rst_opcode", bus.OPCODE, c_IDLE);
    chk("rst_data", bus.DATA, 32'd0);
    chk("rst_count", 32'(bus.COUNT), 32'd0);
    chk("rst_rsp_valid", 32'(bus.RSP_VALID), 32'd0);
    chk("rst_busy", 32'(bus.BUSY), 32'd0);
    chk("rst_err", 32'(bus.ERR), 32'd0);
    chk("rst_cmd_ready", 32'(bus.CMD_READY), 32'd1);

    // Reset while the FIFO holds two entries
    bus.WAIT = 1'b1;
    push(32'hAC000010, 32'h1, 1'b0);
    push(32'h8C000011, 32'h2, 1'b0);
    @(negedge HCLK);
    chk("pre_rst_count", 32'(bus.COUNT), 32'd2);
    @(posedge HCLK); #1 HRESET = 1'b1;
    @(negedge HCLK);
    chk("in_rst_cmd_ready", 32'(bus.CMD_READY), 32'd0);
    @(posedge HCLK); #1 HRESET = 1'b0;
    bus.WAIT = 1'b0;
    @(negedge HCLK);
    chk("mid_rst_count", 32'(bus.COUNT), 32'd0);
    chk("mid_rst_opcode", bus.OPCODE, c_IDLE);
    chk("mid_rst_cmd_ready", 32'(bus.CMD_READY), 32'd1);
    chk("mid_rst_rsp_valid", 32'(bus.RSP_VALID), 32'd0);
    repeat (3) @(negedge HCLK);
    chk("mid_rst_no_issue", bus.OPCODE, c_IDLE);

    // Write held until DONE
    push(32'hAC000001, 32'h12345678, 1'b1);
    wait_issue();
    for (int i = 0; i < 3; i++) begin
      chk("wr_hold_op", bus.OPCODE, 32'hAC000001);
      chk("wr_hold_data", bus.DATA, 32'h12345678);
      if (i == 2) bus.DONE = 1'b1;
      @(negedge HCLK);
    end
    bus.DONE = 1'b0;
    chk("wr_after_op", bus.OPCODE, c_IDLE);
    chk("wr_data_kept", bus.DATA, 32'h12345678);
    chk("wr_no_rsp", 32'(bus.RSP_VALID), 32'd0);
    chk("wr_busy", 32'(bus.BUSY), 32'd0);

    // Read with delayed RSP_READY
    push(32'h8C000001, 32'h0, 1'b1);
    wait_issue();
    bus.RESPONSE      = 32'hDEADBEEF;
    bus.RESPONSE_ADDR = 5'd1;
    bus.DONE          = 1'b1;
    q_rsp.push_back({5'd1, 32'hDEADBEEF});
    @(negedge HCLK);
    bus.DONE = 1'b0;
    chk("rd_rsp_valid0", 32'(bus.RSP_VALID), 32'd1);
    chk("rd_opcode_idle", bus.OPCODE, c_IDLE);
    @(negedge HCLK);
    chk("rd_rsp_valid1", 32'(bus.RSP_VALID), 32'd1);
    chk("rd_rsp_data", bus.RSP_DATA, 32'hDEADBEEF);
    chk("rd_rsp_addr", 32'(bus.RSP_ADDR), 32'd1);
    @(posedge HCLK); #1 bus.RSP_READY = 1'b1;
    @(negedge HCLK);
    @(negedge HCLK);
    chk("rd_rsp_dropped", 32'(bus.RSP_VALID), 32'd0);
    bus.RSP_READY = 1'b0;

    // Fill under WAIT, then drain and wrap the pointers
    bus.WAIT = 1'b1;
    for (int i = 0; i < DEPTH; i++) push(32'hAC000000 | 32'(i + 2), 32'hA0 + 32'(i), 1'b1);
    @(negedge HCLK);
    chk("full_cmd_ready", 32'(bus.CMD_READY), 32'd0);
    chk("full_count", 32'(bus.COUNT), 32'd4);
    chk("full_opcode_idle", bus.OPCODE, c_IDLE);
    chk("full_busy", 32'(bus.BUSY), 32'd1);
    auto_mode     = 1'b1;
    bus.RSP_READY = 1'b1;
    bus.WAIT      = 1'b0;
    wait_drain();
    push(32'hAC000007, 32'hB0, 1'b1);
    push(32'h8C000008, 32'hB1, 1'b1);
    push(32'hAC000009, 32'hB2, 1'b1);
    push(32'h8C00000A, 32'hB3, 1'b1);
    wait_drain();

    // Illegal head is dropped with a single ERR pulse
    e0 = n_err;
    push(32'h00000001, 32'h99, 1'b0);
    push(32'hAC000002, 32'h55, 1'b1);
    wait_drain();
    @(negedge HCLK);
    chk("illegal_err_pulses", 32'(n_err - e0), 32'd1);
    auto_mode = 1'b0;
    @(negedge HCLK);
    bus.DONE = 1'b0;

    // Read whose DONE is delayed, with WAIT active for 5 cycles
    e0 = n_err;
    nw = 0;
    hit = 1'b0;
    push(32'h8C000005, 32'h7, 1'b1);
    wait_issue();
`ifdef CMD_ISSUER_TIMEOUT_EN
    for (int c = 0; c < 40; c++) begin
      bus.WAIT = (c >= 3 && c < 8);
      if (!bus.WAIT) nw++;
      @(negedge HCLK);
      if (bus.ERR) begin
        hit = 1'b1;
        break;
      end
    end
    bus.WAIT = 1'b0;
    chk("tmo_hit", 32'(hit), 32'd1);
    chk("tmo_nonwait_cycles", 32'(nw), 32'd16);
    chk("tmo_opcode_idle", bus.OPCODE, c_IDLE);
    chk("tmo_no_rsp", 32'(bus.RSP_VALID), 32'd0);
    @(negedge HCLK);
    chk("tmo_err_pulses", 32'(n_err - e0), 32'd1);
    chk("tmo_busy", 32'(bus.BUSY), 32'd0);
`else
    for (int c = 0; c < 20; c++) begin
      bus.WAIT = (c >= 3 && c < 8);
      if (!bus.WAIT) nw++;
      @(negedge HCLK);
      if (bus.ERR) hit = 1'b1;
    end
    bus.WAIT = 1'b0;
    chk("hold_no_err", 32'(hit), 32'd0);
    chk("hold_nonwait_cycles", 32'(nw), 32'd15);
    chk("hold_opcode", bus.OPCODE, 32'h8C000005);
    bus.RESPONSE      = 32'hCAFEF00D;
    bus.RESPONSE_ADDR = 5'd5;
    bus.DONE          = 1'b1;
    bus.RSP_READY     = 1'b1;
    q_rsp.push_back({5'd5, 32'hCAFEF00D});
    @(negedge HCLK);
    bus.DONE = 1'b0;
    wait_drain();
    chk("hold_err_pulses", 32'(n_err - e0), 32'd0);
`endif

    repeat (2) @(negedge HCLK);
    chk("iss_queue_empty", 32'(q_iss.size()), 32'd0);
    chk("rsp_queue_empty", 32'(q_rsp.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
